// File: rtl/pipe_pkg.sv
// Shared types for the execute stage: ALU opcodes, forward selects, FSM states.
package pipe_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_MUL  = 4'd10
    } alu_op_t;

    // Operand source selects coming from the forwarding unit; 2'b11 falls back to the register file.
    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } ex_state_t;

    // True when the opcode needs the iterative multiplier.
    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == ALU_MUL);
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX -> EX -> EX/MEM signal bundle. The master side is the pipeline
// around the execute stage; the slave side is the execute stage itself.
interface ex_stage_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
) ();
    logic              id_ex_valid;
    logic [3:0]        id_ex_alu_op;
    logic [DATA_W-1:0] id_ex_rs_data;
    logic [DATA_W-1:0] id_ex_rt_data;
    logic [DATA_W-1:0] id_ex_imm;
    logic              id_ex_alu_src;
    logic [REG_AW-1:0] id_ex_rd;
    logic              id_ex_reg_write;
    logic              id_ex_mem_read;
    logic              id_ex_mem_write;
    logic [1:0]        forward_a;
    logic [1:0]        forward_b;
    logic [DATA_W-1:0] mem_wb_data;
    logic              mem_stall;
    logic              flush;

    logic              ex_stall;
    logic              ex_mem_valid;
    logic              ex_mem_reg_write;
    logic              ex_mem_mem_read;
    logic              ex_mem_mem_write;
    logic [DATA_W-1:0] ex_mem_alu_result;
    logic [DATA_W-1:0] ex_mem_store_data;
    logic [REG_AW-1:0] ex_mem_rd;
    logic              ex_mem_zero;

    modport master (
        output id_ex_valid, id_ex_alu_op, id_ex_rs_data, id_ex_rt_data, id_ex_imm,
               id_ex_alu_src, id_ex_rd, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write,
               forward_a, forward_b, mem_wb_data, mem_stall, flush,
        input  ex_stall, ex_mem_valid, ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write,
               ex_mem_alu_result, ex_mem_store_data, ex_mem_rd, ex_mem_zero
    );

    modport slave (
        input  id_ex_valid, id_ex_alu_op, id_ex_rs_data, id_ex_rt_data, id_ex_imm,
               id_ex_alu_src, id_ex_rd, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write,
               forward_a, forward_b, mem_wb_data, mem_stall, flush,
        output ex_stall, ex_mem_valid, ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write,
               ex_mem_alu_result, ex_mem_store_data, ex_mem_rd, ex_mem_zero
    );
endinterface

// File: rtl/ex_stage_seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per cycle, W cycles.
// Only the low W bits of the product are kept, so the accumulator is W wide.
module seq_multiplier #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_start,
    input  logic         i_abort,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_busy,
    output logic         o_done,
    output logic [W-1:0] o_product
);
    localparam int CNT_W = $clog2(W + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(W);

    logic [W-1:0]     r_acc;
    logic [W-1:0]     r_mcand;
    logic [W-1:0]     r_mplier;
    logic [CNT_W-1:0] r_count;

    // Load operands on start, then add-and-shift once per cycle until the counter expires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= {W{1'b0}};
            r_mcand  <= {W{1'b0}};
            r_mplier <= {W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else if (i_abort) begin
            r_count  <= {CNT_W{1'b0}};
        end else if (i_start) begin
            r_acc    <= {W{1'b0}};
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_count  <= CNT_LOAD;
        end else if (r_count != {CNT_W{1'b0}}) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= {r_mcand[W-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[W-1:1]};
            r_count  <= r_count - CNT_ONE;
        end
    end

    // Busy while iterations remain; done flags the final iteration, so the
    // product register is complete right after the current edge.
    assign o_busy    = (r_count != {CNT_W{1'b0}});
    assign o_done    = (r_count == CNT_ONE);
    assign o_product = r_acc;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, MUL sequencing and the EX/MEM register.
module ex_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    ex_stage_if.slave bus
);
    localparam int SH_W = $clog2(DATA_W);

    logic [DATA_W-1:0] w_op_a;
    logic [DATA_W-1:0] w_fwd_b;
    logic [DATA_W-1:0] w_op_b;
    logic [DATA_W-1:0] w_alu;
    logic [DATA_W-1:0] w_result;
    logic [DATA_W-1:0] w_mul_product;
    logic [SH_W-1:0]   w_shamt;
    logic              w_is_mul;
    logic              w_mul_enter;
    logic              w_mul_start;
    logic              w_mul_busy;
    logic              w_mul_done;
    logic              w_bubble;

    ex_state_t         r_state;
    logic              r_ex_mem_valid;
    logic              r_ex_mem_reg_write;
    logic              r_ex_mem_mem_read;
    logic              r_ex_mem_mem_write;
    logic [DATA_W-1:0] r_ex_mem_alu_result;
    logic [DATA_W-1:0] r_ex_mem_store_data;
    logic [REG_AW-1:0] r_ex_mem_rd;
    logic              r_ex_mem_zero;

    // Operand A source select; EX/MEM forwarding taps the registered result, so no loop.
    always_comb begin
        w_op_a = bus.id_ex_rs_data;
        case (bus.forward_a)
            FWD_EXMEM: w_op_a = r_ex_mem_alu_result;
            FWD_MEMWB: w_op_a = bus.mem_wb_data;
            default:   w_op_a = bus.id_ex_rs_data;
        endcase
    end

    // Forwarded operand B (also the store data) and the immediate mux behind it.
    always_comb begin
        w_fwd_b = bus.id_ex_rt_data;
        case (bus.forward_b)
            FWD_EXMEM: w_fwd_b = r_ex_mem_alu_result;
            FWD_MEMWB: w_fwd_b = bus.mem_wb_data;
            default:   w_fwd_b = bus.id_ex_rt_data;
        endcase
        if (bus.id_ex_alu_src) begin
            w_op_b = bus.id_ex_imm;
        end else begin
            w_op_b = w_fwd_b;
        end
    end

    assign w_shamt = w_op_b[SH_W-1:0];

    // Single-cycle ALU; MUL and unused opcodes produce zero here.
    always_comb begin
        w_alu = {DATA_W{1'b0}};
        case (bus.id_ex_alu_op)
            ALU_ADD:  w_alu = w_op_a + w_op_b;
            ALU_SUB:  w_alu = w_op_a - w_op_b;
            ALU_AND:  w_alu = w_op_a & w_op_b;
            ALU_OR:   w_alu = w_op_a | w_op_b;
            ALU_XOR:  w_alu = w_op_a ^ w_op_b;
            ALU_SLL:  w_alu = w_op_a << w_shamt;
            ALU_SRL:  w_alu = w_op_a >> w_shamt;
            ALU_SRA:  w_alu = $unsigned($signed(w_op_a) >>> w_shamt);
            ALU_SLT:  w_alu = {{(DATA_W-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
            ALU_SLTU: w_alu = {{(DATA_W-1){1'b0}}, (w_op_a < w_op_b)};
            default:  w_alu = {DATA_W{1'b0}};
        endcase
    end

    assign w_is_mul    = bus.id_ex_valid && is_mul_op(bus.id_ex_alu_op);
    assign w_mul_enter = (r_state == IDLE) && w_is_mul;
    assign w_mul_start = w_mul_enter && !bus.flush;
    assign w_result    = (r_state == DONE) ? w_mul_product : w_alu;
    assign w_bubble    = bus.flush || w_mul_enter || (r_state == BUSY);

    // Upstream holds while downstream stalls, a MUL is being launched or iterating.
    // Low in DONE so the MUL leaves ID/EX exactly once.
    assign bus.ex_stall = bus.mem_stall || w_mul_enter || (r_state == BUSY);

    seq_multiplier #(
        .W (DATA_W)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_mul_start),
        .i_abort   (bus.flush),
        .i_a       (w_op_a),
        .i_b       (w_fwd_b),
        .o_busy    (w_mul_busy),
        .o_done    (w_mul_done),
        .o_product (w_mul_product)
    );

    // MUL sequencing FSM; flush aborts from any state, DONE waits out mem_stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_mul_start) begin
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.flush) begin
                        r_state <= IDLE;
                    end else if (w_mul_done) begin
                        r_state <= DONE;
                    end else if (!w_mul_busy) begin
                        // Multiplier lost its count without finishing: recover to IDLE.
                        r_state <= IDLE;
                    end
                end
                DONE: begin
                    if (bus.flush || !bus.mem_stall) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // EX/MEM register: hold on mem_stall, bubble on flush/MUL in flight, else load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_mem_valid      <= 1'b0;
            r_ex_mem_reg_write  <= 1'b0;
            r_ex_mem_mem_read   <= 1'b0;
            r_ex_mem_mem_write  <= 1'b0;
            r_ex_mem_alu_result <= {DATA_W{1'b0}};
            r_ex_mem_store_data <= {DATA_W{1'b0}};
            r_ex_mem_rd         <= {REG_AW{1'b0}};
            r_ex_mem_zero       <= 1'b0;
        end else if (bus.mem_stall) begin
            r_ex_mem_valid      <= r_ex_mem_valid;
        end else if (w_bubble) begin
            r_ex_mem_valid      <= 1'b0;
            r_ex_mem_reg_write  <= 1'b0;
            r_ex_mem_mem_read   <= 1'b0;
            r_ex_mem_mem_write  <= 1'b0;
            r_ex_mem_alu_result <= {DATA_W{1'b0}};
            r_ex_mem_store_data <= {DATA_W{1'b0}};
            r_ex_mem_rd         <= {REG_AW{1'b0}};
            r_ex_mem_zero       <= 1'b0;
        end else begin
            r_ex_mem_valid      <= bus.id_ex_valid;
            r_ex_mem_reg_write  <= bus.id_ex_reg_write;
            r_ex_mem_mem_read   <= bus.id_ex_mem_read;
            r_ex_mem_mem_write  <= bus.id_ex_mem_write;
            r_ex_mem_alu_result <= w_result;
            r_ex_mem_store_data <= w_fwd_b;
            r_ex_mem_rd         <= bus.id_ex_rd;
            r_ex_mem_zero       <= (w_result == {DATA_W{1'b0}});
        end
    end

    assign bus.ex_mem_valid      = r_ex_mem_valid;
    assign bus.ex_mem_reg_write  = r_ex_mem_reg_write;
    assign bus.ex_mem_mem_read   = r_ex_mem_mem_read;
    assign bus.ex_mem_mem_write  = r_ex_mem_mem_write;
    assign bus.ex_mem_alu_result = r_ex_mem_alu_result;
    assign bus.ex_mem_store_data = r_ex_mem_store_data;
    assign bus.ex_mem_rd         = r_ex_mem_rd;
    assign bus.ex_mem_zero       = r_ex_mem_zero;

endmodule
